// File: rtl/rr_readout_arbiter_pkg.sv
// Shared types and helpers for the N-channel readout arbiter.
package rr_readout_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never below 1 so a single channel still gets an index bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_readout_arbiter_pick.sv
// Combinational picker: first requesting index at or after ptr (cyclic), or lowest index in fixed mode.
module rr_pick
  import rr_readout_arbiter_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IDW       = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDW-1:0]      ptr,
  input  logic                excl_en,
  input  logic [IDW-1:0]      excl,
  output logic                valid,
  output logic [IDW-1:0]      idx
);

  logic [CHANNELS-1:0]   cand;
  logic [CHANNELS-1:0]   hi_mask;
  logic [2*CHANNELS-1:0] dbl;

  always_comb begin
    cand    = req;
    hi_mask = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (excl_en && (excl == IDW'(i))) cand[i] = 1'b0;
      if (!FIXED_PRIO)                  hi_mask[i] = (IDW'(i) >= ptr);
    end
  end

  // Lower half holds requests at/after ptr; upper half wraps around to the rest.
  assign dbl   = {cand, cand & hi_mask};
  assign valid = |cand;

  always_comb begin
    idx = '0;
    for (int i = 2*CHANNELS-1; i >= 0; i--) begin
      if (dbl[i]) idx = (i >= CHANNELS) ? IDW'(i - CHANNELS) : IDW'(i);
    end
  end

endmodule

// File: rtl/rr_readout_arbiter.sv
// Readout arbiter merging N channel FWFT FIFOs into one stream for sram_fifo.
module rr_readout_arbiter
  import rr_readout_arbiter_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter bit FIXED_PRIO = 1'b0,
  parameter bit TAG_ID     = 1'b0,
  localparam int IDW       = clog2_min1(CHANNELS)
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST,
  input  logic [CHANNELS-1:0]            CH_EN,
  input  logic [CHANNELS-1:0]            WRITE_REQ,
  input  logic [CHANNELS-1:0]            HOLD_REQ,
  input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
  output logic [CHANNELS-1:0]            READ_GRANT,
  input  logic                           READY_OUT,
  output logic                           WRITE_OUT,
  output logic [DATA_WIDTH-1:0]          DATA_OUT,
  output logic [IDW-1:0]                 OWNER
);

  localparam int            CW         = clog2_min1(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CW'(MAX_BURST - 1);

  arb_state_e      state, state_n;
  logic [IDW-1:0]  owner, owner_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [CW-1:0]   count, count_n;

  logic [CHANNELS-1:0] elig;
  logic                in_grant, own_en, own_req, own_hold;
  logic                xfer, burst_end, rel;
  logic [IDW-1:0]      ptr_inc, pick_ptr, pick_idx;
  logic                pick_valid;
  logic [DATA_WIDTH-1:0] word;

  assign elig     = CH_EN & WRITE_REQ;
  assign in_grant = (state == ST_GRANT);
  assign own_en   = CH_EN[owner];
  assign own_req  = WRITE_REQ[owner];
  assign own_hold = HOLD_REQ[owner];
  assign ptr_inc  = (owner == IDW'(CHANNELS - 1)) ? '0 : owner + 1'b1;

  // A word offered during reset must not be popped or written downstream.
  assign WRITE_OUT = in_grant & own_en & own_req & ~BUS_RST;
  assign xfer      = WRITE_OUT & READY_OUT;
  assign burst_end = (MAX_BURST != 0) && xfer && !own_hold && (count == BURST_LAST);
  assign rel       = in_grant & (~own_en | (~own_hold & ~own_req) | burst_end);

  // One picker serves both the IDLE pick and the handover on release.
  assign pick_ptr = in_grant ? ptr_inc : ptr;

  rr_pick #(
    .CHANNELS   (CHANNELS),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req     (elig),
    .ptr     (pick_ptr),
    .excl_en (in_grant),
    .excl    (owner),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    count_n = count;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_GRANT;
          owner_n = pick_idx;
          count_n = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          ptr_n   = ptr_inc;
          count_n = '0;
          if (pick_valid) owner_n = pick_idx;
          else            state_n = ST_IDLE;
        end else if (xfer && (count != BURST_MAX)) begin
          count_n = count + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      count <= count_n;
    end
  end

  always_comb begin
    READ_GRANT = '0;
    word       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (owner == IDW'(i)) begin
        READ_GRANT[i] = xfer;
        word          = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (TAG_ID) word[DATA_WIDTH-1 -: IDW] = owner;
  end

  assign DATA_OUT = in_grant ? word : '0;
  assign OWNER    = owner;

  a_grant_onehot: assert property (@(posedge BUS_CLK) $onehot0(READ_GRANT));
  a_grant_req:    assert property (@(posedge BUS_CLK) (READ_GRANT & ~WRITE_REQ) == '0);

endmodule
